// File: rtl/bp_cfg_responder.sv
// bp_cfg_responder
// Per-core configuration-bus responder. Claims requests addressed to this
// core's ID or to the all-ones broadcast ID, applies writes to a small
// register file that drives the core/CCE control outputs, and returns read
// data for exact-ID reads on a registered valid/yumi channel.
module bp_cfg_responder #(
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [cfg_core_width_p-1:0] my_core_id_i,

    input  logic                        cfg_v_i,
    output logic                        cfg_ready_o,
    input  logic                        cfg_w_i,
    input  logic [cfg_core_width_p-1:0] cfg_core_i,
    input  logic [cfg_addr_width_p-1:0] cfg_addr_i,
    input  logic [cfg_data_width_p-1:0] cfg_data_i,

    output logic                        resp_v_o,
    output logic [cfg_data_width_p-1:0] resp_data_o,
    input  logic                        resp_yumi_i,

    output logic                        freeze_o,
    output logic                        cce_mode_o,
    output logic [7:0]                  domain_mask_o,
    output logic [cfg_data_width_p-1:0] scratch_o
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RESP = 1'b1;

    localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE   = cfg_addr_width_p'(0);
    localparam logic [cfg_addr_width_p-1:0] ADDR_CCE_MODE = cfg_addr_width_p'(1);
    localparam logic [cfg_addr_width_p-1:0] ADDR_DOMAIN   = cfg_addr_width_p'(2);
    localparam logic [cfg_addr_width_p-1:0] ADDR_SCRATCH  = cfg_addr_width_p'(3);
    localparam logic [cfg_addr_width_p-1:0] ADDR_WR_COUNT = cfg_addr_width_p'(4);

    logic [0:0]                  state_r;
    logic [cfg_data_width_p-1:0] resp_data_r;

    logic                        freeze_r;
    logic                        cce_mode_r;
    logic [7:0]                  domain_mask_r;
    logic [cfg_data_width_p-1:0] scratch_r;
    logic [15:0]                 wr_count_r;

    logic                        accept;
    logic                        is_bcast;
    logic                        is_exact;
    logic                        wr_en;
    logic                        rd_en;
    logic [cfg_data_width_p-1:0] rd_data;

    // A request addressed to all-ones is always treated as broadcast, even
    // if this core's own ID happens to be all-ones, so it never produces a
    // read response.
    assign cfg_ready_o = (state_r == STATE_IDLE);
    assign accept      = cfg_v_i & cfg_ready_o;
    assign is_bcast    = &cfg_core_i;
    assign is_exact    = (cfg_core_i == my_core_id_i) & ~is_bcast;
    assign wr_en       = accept & cfg_w_i & (is_exact | is_bcast);
    assign rd_en       = accept & ~cfg_w_i & is_exact;

    assign resp_v_o      = (state_r == STATE_RESP);
    assign resp_data_o   = resp_data_r;
    assign freeze_o      = freeze_r;
    assign cce_mode_o    = cce_mode_r;
    assign domain_mask_o = domain_mask_r;
    assign scratch_o     = scratch_r;

    // Read mux: zero-extended register contents, zero for unmapped addresses
    always_comb begin
        rd_data = '0;
        case (cfg_addr_i)
            ADDR_FREEZE:   rd_data[0]    = freeze_r;
            ADDR_CCE_MODE: rd_data[0]    = cce_mode_r;
            ADDR_DOMAIN:   rd_data[7:0]  = domain_mask_r;
            ADDR_SCRATCH:  rd_data       = scratch_r;
            ADDR_WR_COUNT: rd_data[15:0] = wr_count_r;
            default:       rd_data       = '0;
        endcase
    end

    // Response FSM: capture read data at acceptance, hold it until yumi
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= STATE_IDLE;
            resp_data_r <= '0;
        end else begin
            case (state_r)
                STATE_IDLE: begin
                    if (rd_en) begin
                        state_r     <= STATE_RESP;
                        resp_data_r <= rd_data;
                    end
                end
                STATE_RESP: begin
                    if (resp_yumi_i) begin
                        state_r <= STATE_IDLE;
                    end
                end
                default: state_r <= STATE_IDLE;
            endcase
        end
    end

    // Register file: matched writes update the addressed field and always
    // bump the write counter, even when the address is read-only or unmapped
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            freeze_r      <= 1'b1;
            cce_mode_r    <= 1'b0;
            domain_mask_r <= 8'h01;
            scratch_r     <= '0;
            wr_count_r    <= '0;
        end else if (wr_en) begin
            wr_count_r <= wr_count_r + 16'd1;
            case (cfg_addr_i)
                ADDR_FREEZE:   freeze_r      <= cfg_data_i[0];
                ADDR_CCE_MODE: cce_mode_r    <= cfg_data_i[0];
                ADDR_DOMAIN:   domain_mask_r <= cfg_data_i[7:0];
                ADDR_SCRATCH:  scratch_r     <= cfg_data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_cfg_responder.sv
// tb_bp_cfg_responder
// Directed self-checking bench for bp_cfg_responder with hand-computed
// expected values.
module tb_bp_cfg_responder;

    logic        clk;
    logic        reset_n;
    logic [7:0]  my_core_id;
    logic        cfg_v;
    logic        cfg_ready;
    logic        cfg_w;
    logic [7:0]  cfg_core;
    logic [15:0] cfg_addr;
    logic [63:0] cfg_data;
    logic        resp_v;
    logic [63:0] resp_data;
    logic        resp_yumi;
    logic        freeze;
    logic        cce_mode;
    logic [7:0]  domain_mask;
    logic [63:0] scratch;

    int checks   = 0;
    int failures = 0;

    bp_cfg_responder #(
        .cfg_core_width_p(8),
        .cfg_addr_width_p(16),
        .cfg_data_width_p(64)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .my_core_id_i (my_core_id),
        .cfg_v_i      (cfg_v),
        .cfg_ready_o  (cfg_ready),
        .cfg_w_i      (cfg_w),
        .cfg_core_i   (cfg_core),
        .cfg_addr_i   (cfg_addr),
        .cfg_data_i   (cfg_data),
        .resp_v_o     (resp_v),
        .resp_data_o  (resp_data),
        .resp_yumi_i  (resp_yumi),
        .freeze_o     (freeze),
        .cce_mode_o   (cce_mode),
        .domain_mask_o(domain_mask),
        .scratch_o    (scratch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle request; returns 1 ns after the accepting edge
    task automatic do_req(input logic w, input logic [7:0] core,
                          input logic [15:0] addr, input logic [63:0] data);
        @(negedge clk);
        cfg_v    = 1'b1;
        cfg_w    = w;
        cfg_core = core;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_v = 1'b0;
    endtask

    task automatic do_yumi();
        @(negedge clk);
        resp_yumi = 1'b1;
        @(posedge clk);
        #1;
        resp_yumi = 1'b0;
        check("yumi_resp_v_low", resp_v, 1'b0);
        check("yumi_ready_high", cfg_ready, 1'b1);
    endtask

    initial begin
        reset_n    = 1'b0;
        my_core_id = 8'h03;
        cfg_v      = 1'b0;
        cfg_w      = 1'b0;
        cfg_core   = '0;
        cfg_addr   = '0;
        cfg_data   = '0;
        resp_yumi  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", cfg_ready, 1'b1);
        check("rst_resp_v", resp_v, 1'b0);
        check("rst_resp_data", resp_data, 64'h0);
        check("rst_freeze", freeze, 1'b1);
        check("rst_cce_mode", cce_mode, 1'b0);
        check("rst_mask", domain_mask, 8'h01);
        check("rst_scratch", scratch, 64'h0);

        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_freeze", freeze, 1'b1);
        check("idle_mask", domain_mask, 8'h01);
        check("idle_ready", cfg_ready, 1'b1);

        // Disturb some registers, then pulse reset mid-run
        do_req(1'b1, 8'h03, 16'h0001, 64'h3);
        check("cce_mode_low_bit", cce_mode, 1'b1);
        do_req(1'b1, 8'h03, 16'h0002, 64'h55);
        check("mask_55", domain_mask, 8'h55);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("pulse_cce_mode", cce_mode, 1'b0);
        check("pulse_mask", domain_mask, 8'h01);
        check("pulse_freeze", freeze, 1'b1);
        check("pulse_ready", cfg_ready, 1'b1);

        // Own-ID write vs foreign-ID write
        do_req(1'b1, 8'h03, 16'h0000, 64'h0);
        check("own_write_freeze", freeze, 1'b0);
        do_req(1'b1, 8'h05, 16'h0000, 64'h1);
        check("other_id_freeze", freeze, 1'b0);

        // Broadcast write truncates to 8 bits; wr_count = own + broadcast = 2
        do_req(1'b1, 8'hFF, 16'h0002, 64'h1AB);
        check("bcast_mask", domain_mask, 8'hAB);
        do_req(1'b0, 8'h03, 16'h0004, 64'h0);
        check("wr_count_resp_v", resp_v, 1'b1);
        check("wr_count_value", resp_data, 64'h2);
        do_yumi();

        // Broadcast read is dropped
        do_req(1'b0, 8'hFF, 16'h0002, 64'h0);
        check("bcast_rd_resp_v", resp_v, 1'b0);
        check("bcast_rd_ready", cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        check("bcast_rd_resp_v_later", resp_v, 1'b0);

        // Write then immediate read of scratch, held response
        do_req(1'b1, 8'h03, 16'h0003, 64'hDEADBEEF_CAFEF00D);
        check("scratch_write", scratch, 64'hDEADBEEF_CAFEF00D);
        do_req(1'b0, 8'h03, 16'h0003, 64'h0);
        check("scratch_rd_resp_v", resp_v, 1'b1);
        check("scratch_rd_data", resp_data, 64'hDEADBEEF_CAFEF00D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_resp_v", resp_v, 1'b1);
            check("hold_resp_data", resp_data, 64'hDEADBEEF_CAFEF00D);
            check("hold_ready", cfg_ready, 1'b0);
        end

        // Request presented in the yumi cycle must not be accepted
        @(negedge clk);
        resp_yumi = 1'b1;
        cfg_v     = 1'b1;
        cfg_w     = 1'b1;
        cfg_core  = 8'h03;
        cfg_addr  = 16'h0003;
        cfg_data  = 64'h1234;
        @(posedge clk);
        #1;
        resp_yumi = 1'b0;
        cfg_v     = 1'b0;
        check("yumi_cycle_resp_v", resp_v, 1'b0);
        check("yumi_cycle_ready", cfg_ready, 1'b1);
        check("yumi_cycle_write_blocked", scratch, 64'hDEADBEEF_CAFEF00D);

        // More reads: domain mask zero-extended, unmapped, freeze
        do_req(1'b0, 8'h03, 16'h0002, 64'h0);
        check("mask_rd_data", resp_data, 64'hAB);
        do_yumi();
        do_req(1'b0, 8'h03, 16'h0100, 64'h0);
        check("unmapped_rd_resp_v", resp_v, 1'b1);
        check("unmapped_rd_data", resp_data, 64'h0);
        do_yumi();
        do_req(1'b0, 8'h03, 16'h0000, 64'h0);
        check("freeze_rd_data", resp_data, 64'h0);
        do_yumi();

        // 65537 matched writes to unmapped address: wr_count wraps to 1
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        cfg_v    = 1'b1;
        cfg_w    = 1'b1;
        cfg_core = 8'h03;
        cfg_addr = 16'h0100;
        cfg_data = '1;
        repeat (65537) @(posedge clk);
        #1;
        cfg_v = 1'b0;
        check("burst_freeze", freeze, 1'b1);
        check("burst_cce_mode", cce_mode, 1'b0);
        check("burst_mask", domain_mask, 8'h01);
        check("burst_scratch", scratch, 64'h0);
        do_req(1'b0, 8'h03, 16'h0004, 64'h0);
        check("wrap_wr_count", resp_data, 64'h1);
        do_yumi();

        // Reset while a response is pending
        do_req(1'b0, 8'h03, 16'h0000, 64'h0);
        check("pre_rst_resp_v", resp_v, 1'b1);
        check("pre_rst_resp_data", resp_data, 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_resp_v", resp_v, 1'b0);
        check("async_rst_ready", cfg_ready, 1'b1);
        check("async_rst_resp_data", resp_data, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stale_resp_gone", resp_v, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
